// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch sequencer:
//   INSTR_W            instruction word width (18-bit processor)
//   FETCH_TIMEOUT_CYC  default FETCH-cycle budget when the fetch timeout is built
//   state_t            sequencer FSM states
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INSTR_W           = 18;
    localparam int FETCH_TIMEOUT_CYC = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_ISSUE = 3'd3,
        ST_EXEC  = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_pc.sv
// -----------------------------------------------------------------------------
// fetch_pc
// Program counter register. Load beats increment; the increment wraps modulo
// 2^ADDR_W.
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset (PC <= RESET_PC)
//   inc_i       advance PC by one
//   load_i      take load_val_i (priority over inc_i)
//   load_val_i  branch target
//   pc_o        current PC
// -----------------------------------------------------------------------------
module fetch_pc #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i)
            pc_d = load_val_i;
        else if (inc_i)
            pc_d = pc_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pc_q <= ADDR_W'(RESET_PC);
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller: reads the word at PC from program memory,
// writes it into the IR (wr_IR pulse), then has the IR present it to the
// decoder (re_IR pulse) and waits for the execute stage.
//
// Build option: FETCH_TIMEOUT_EN -- bound FETCH to TIMEOUT_CYC cycles without
// mem_ack; on expiry go IDLE and raise sticky fetch_err (run then ignored
// until reset). Without it FETCH waits forever and fetch_err is tied 0.
//
// Ports:
//   clk, rst            clock / asynchronous active-low reset
//   run, halt           start fetching (sampled in IDLE) / stop after current instr
//   mem_re, mem_addr    memory read request (held until ack) and address (= PC)
//   mem_ack, mem_data   read data valid / instruction word
//   IRin, wr_IR, re_IR  IR data, IR write pulse, IR read pulse
//   exec_done           execute stage finished current instruction
//   pc_load, pc_in      with exec_done in EXEC: branch to pc_in
//   pc_out              current PC
//   busy                high in every state except IDLE
//   fetch_err           sticky fetch timeout flag
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int RESET_PC    = 0,
    parameter int TIMEOUT_CYC = FETCH_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               halt,
    output logic               mem_re,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] IRin,
    output logic               wr_IR,
    output logic               re_IR,
    input  logic               exec_done,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               busy,
    output logic               fetch_err
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_t             state_q, state_d;
    logic               halt_pend_q, halt_pend_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               pc_inc, pc_ld;
    logic [ADDR_W-1:0]  pc;
    logic               run_ok;
    logic               timeout;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (pc_inc),
        .load_i     (pc_ld),
        .load_val_i (pc_in),
        .pc_o       (pc)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Counts completed FETCH cycles without ack; any other state zeroes it,
    // so it is already clear on FETCH entry.
    assign timeout = (state_q == ST_FETCH) && !mem_ack &&
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if (state_q == ST_FETCH && !mem_ack)
            cnt_d = cnt_q + CNT_W'(1);
        if (timeout)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
    assign run_ok    = run & ~err_q;
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
    assign run_ok    = run;
`endif

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        mem_re  = 1'b0;
        wr_IR   = 1'b0;
        re_IR   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_ok)
                    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_re = 1'b1;
                if (mem_ack) begin
                    ir_d    = mem_data;
                    pc_inc  = 1'b1;
                    state_d = ST_WRITE;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                wr_IR   = 1'b1;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                re_IR   = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_done) begin
                    // PC was already incremented at capture; a load replaces it.
                    pc_ld   = pc_load;
                    state_d = (halt_pend_q || halt) ? ST_IDLE : ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // halt is remembered while busy and only acted on at EXEC exit.
    always_comb begin
        halt_pend_d = halt_pend_q;
        if (state_d == ST_IDLE)
            halt_pend_d = 1'b0;
        else if (state_q != ST_IDLE && halt)
            halt_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            halt_pend_q <= 1'b0;
            ir_q        <= '0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            ir_q        <= ir_d;
        end
    end

    assign IRin     = ir_q;
    assign mem_addr = pc;
    assign pc_out   = pc;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer with hand-computed expectations.
// Build option: FETCH_TIMEOUT_EN enables the timeout scenario.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run, halt;
    logic        mem_re;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [17:0] mem_data;
    logic [17:0] IRin;
    logic        wr_IR, re_IR;
    logic        exec_done, pc_load;
    logic [7:0]  pc_in, pc_out;
    logic        busy, fetch_err;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_sequencer #(
        .ADDR_W      (8),
        .RESET_PC    (0),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .halt      (halt),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .IRin      (IRin),
        .wr_IR     (wr_IR),
        .re_IR     (re_IR),
        .exec_done (exec_done),
        .pc_load   (pc_load),
        .pc_in     (pc_in),
        .pc_out    (pc_out),
        .busy      (busy),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wr_IR and re_IR must never coincide.
    always @(negedge clk)
        if (rst) chk("wr_re_overlap", {31'b0, wr_IR & re_IR}, 32'd0);

    initial begin
        rst = 1'b0; run = 1'b0; halt = 1'b0; mem_ack = 1'b0; mem_data = '0;
        exec_done = 1'b0; pc_load = 1'b0; pc_in = '0;
        #12;
        chk("rst_busy",   busy,   0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_wr",     wr_IR,  0);
        chk("rst_re",     re_IR,  0);
        chk("rst_ir",     IRin,   0);
        chk("rst_pc",     pc_out, 0);
        chk("rst_err",    fetch_err, 0);
        rst = 1'b1;
        tick();
        // halt in IDLE with no run is ignored
        halt = 1'b1; tick(); halt = 1'b0;
        chk("idle_halt_busy", busy, 0);

        // zero-wait fetch
        run = 1'b1; tick(); run = 1'b0;                 // cycle 1
        chk("zw_mem_re", mem_re, 1);
        chk("zw_addr",   mem_addr, 0);
        chk("zw_busy",   busy, 1);
        mem_ack = 1'b1; mem_data = 18'h2A5A5;
        tick(); mem_ack = 1'b0;                         // cycle 2
        chk("zw_wr",     wr_IR, 1);
        chk("zw_ir",     IRin, 18'h2A5A5);
        chk("zw_re_c2",  re_IR, 0);
        chk("zw_mre_c2", mem_re, 0);
        chk("zw_pc",     pc_out, 1);
        tick();                                         // cycle 3
        chk("zw_re",     re_IR, 1);
        chk("zw_wr_c3",  wr_IR, 0);
        tick();                                         // cycle 4, EXEC
        chk("ex_re",     re_IR, 0);
        chk("ex_busy",   busy, 1);
        tick();
        chk("ex_wait",   mem_re, 0);
        exec_done = 1'b1; tick(); exec_done = 1'b0;     // back-to-back
        chk("b2b_mem_re", mem_re, 1);
        chk("b2b_addr",   mem_addr, 1);

        // three wait cycles
        for (int i = 0; i < 3; i++) begin
            chk("ws_mem_re", mem_re, 1);
            chk("ws_addr",   mem_addr, 1);
            tick();
        end
        chk("ws_mem_re4", mem_re, 1);
        chk("ws_addr4",   mem_addr, 1);
        chk("ws_no_wr",   wr_IR, 0);
        mem_ack = 1'b1; mem_data = 18'h1234F;
        tick(); mem_ack = 1'b0;
        chk("ws_wr",     wr_IR, 1);
        chk("ws_ir",     IRin, 18'h1234F);
        chk("ws_mre_off", mem_re, 0);
        tick();
        chk("ws_re",     re_IR, 1);
        tick();

        // branch to 0xFF, then wrap
        exec_done = 1'b1; pc_load = 1'b1; pc_in = 8'hFF;
        tick(); exec_done = 1'b0; pc_load = 1'b0;
        chk("br_addr_ff", mem_addr, 8'hFF);
        mem_ack = 1'b1; mem_data = 18'h3FFFF;
        tick(); mem_ack = 1'b0;
        chk("wrap_pc",   pc_out, 0);
        tick(); tick();
        exec_done = 1'b1; pc_load = 1'b1; pc_in = 8'h40;
        tick();
        chk("br_addr_40", mem_addr, 8'h40);
        chk("br_pc_40",   pc_out, 8'h40);
        // pc_load outside EXEC is ignored
        pc_in = 8'h77;
        tick(); exec_done = 1'b0; pc_load = 1'b0;
        chk("ld_fetch_ign", mem_addr, 8'h40);

        // halt during WRITE
        mem_ack = 1'b1; mem_data = 18'h0ABCD;
        tick(); mem_ack = 1'b0;
        chk("h_wr", wr_IR, 1);
        halt = 1'b1; tick(); halt = 1'b0;
        chk("h_re",   re_IR, 1);
        chk("h_busy", busy, 1);
        tick();
        // mem_ack outside FETCH is ignored
        mem_ack = 1'b1; mem_data = 18'h11111;
        tick(); mem_ack = 1'b0;
        chk("ack_ign_ir",   IRin, 18'h0ABCD);
        chk("ack_ign_busy", busy, 1);
        exec_done = 1'b1; tick(); exec_done = 1'b0;
        chk("h_idle_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            chk("h_no_mem_re", mem_re, 0);
            tick();
        end
        chk("h_pc", pc_out, 8'h41);

        // reset during ISSUE
        run = 1'b1; tick(); run = 1'b0;
        chk("r_addr", mem_addr, 8'h41);
        mem_ack = 1'b1; mem_data = 18'h00002;
        tick(); mem_ack = 1'b0;
        tick();
        chk("r_in_issue", re_IR, 1);
        #2 rst = 1'b0; #1;
        chk("r_re",     re_IR, 0);
        chk("r_wr",     wr_IR, 0);
        chk("r_busy",   busy, 0);
        chk("r_mem_re", mem_re, 0);
        chk("r_pc",     pc_out, 0);
        chk("r_ir",     IRin, 0);
        tick();
        #2 rst = 1'b1;
        tick();
        run = 1'b1; tick(); run = 1'b0;
        chk("rr_mem_re", mem_re, 1);
        chk("rr_addr",   mem_addr, 0);
        mem_ack = 1'b1; mem_data = 18'h00003;
        tick(); mem_ack = 1'b0;
        tick(); tick();
        halt = 1'b1; exec_done = 1'b1; tick(); halt = 1'b0; exec_done = 1'b0;
        chk("rr_idle", busy, 0);

`ifdef FETCH_TIMEOUT_EN
        run = 1'b1; tick(); run = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("to_mem_re", mem_re, 1);
            tick();
        end
        chk("to_mem_re_off", mem_re, 0);
        chk("to_err",        fetch_err, 1);
        chk("to_busy",       busy, 0);
        chk("to_pc",         pc_out, 1);
        run = 1'b1; tick(); tick(); run = 1'b0;
        chk("to_run_ign", busy, 0);
        chk("to_sticky",  fetch_err, 1);
        #2 rst = 1'b0; #1;
        chk("to_err_clr", fetch_err, 0);
        tick();
        #2 rst = 1'b1;
`else
        chk("no_to_err", fetch_err, 0);
`endif
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
